// File: rtl/riscv_dp_storeenc.sv
// Store-path encoder: rotates sb/sh/sw data into byte lanes, builds lane
// strobes and drives a req/ack write port, splitting word-crossing stores
// into two word-aligned beats.
module riscv_dp_storeenc #(
    parameter int MP_DATA_WIDTH = 32,
    parameter int MP_ADDR_WIDTH = 32
) (
    input  logic                     iclk,
    input  logic                     irst,
    input  logic                     ivalid,
    output logic                     oready,
    input  logic [MP_ADDR_WIDTH-1:0] iaddr,
    input  logic [MP_DATA_WIDTH-1:0] idata,
    input  logic [2:0]               ifunct3,
    output logic                     omem_req,
    input  logic                     imem_ack,
    output logic [MP_ADDR_WIDTH-1:0] omem_addr,
    output logic [MP_DATA_WIDTH-1:0] omem_wdata,
    output logic [3:0]               omem_wstrb,
    output logic                     odone,
    output logic                     oerr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ0,
        S_REQ1,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [MP_ADDR_WIDTH-1:0] base_q;
    logic [MP_DATA_WIDTH-1:0] wdata_q;
    logic [3:0]               strb0_q;
    logic [3:0]               strb1_q;
    logic                     err_q;

    logic                       accept;
    logic [1:0]                 off;
    logic [5:0]                 rot_amt;
    logic [2*MP_DATA_WIDTH-1:0] rot_wide;
    logic [3:0]                 base_mask;
    logic [6:0]                 mask_wide;
    logic                       legal;

    assign accept = ivalid && (state_q == S_IDLE);

    // Decode the incoming store: lane rotation, shifted strobe mask, legality.
    always_comb begin
        off       = iaddr[1:0];
        rot_amt   = {1'b0, off, 3'b000};
        rot_wide  = {idata, idata} << rot_amt;
        base_mask = 4'b0000;
        legal     = 1'b1;
        case (ifunct3)
            3'b000:  base_mask = 4'b0001;
            3'b001:  base_mask = 4'b0011;
            3'b010:  base_mask = 4'b1111;
            default: legal     = 1'b0;
        endcase
        mask_wide = {3'b000, base_mask} << off;
    end

    // Capture the store at accept so later input changes cannot disturb it.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            base_q  <= '0;
            wdata_q <= '0;
            strb0_q <= 4'b0000;
            strb1_q <= 4'b0000;
            err_q   <= 1'b0;
        end else if (accept) begin
            base_q  <= {iaddr[MP_ADDR_WIDTH-1:2], 2'b00};
            wdata_q <= rot_wide[2*MP_DATA_WIDTH-1:MP_DATA_WIDTH];
            strb0_q <= mask_wide[3:0];
            strb1_q <= {1'b0, mask_wide[6:4]};
            err_q   <= ~legal;
        end else if (state_q == S_DONE) begin
            err_q   <= 1'b0;
        end
    end

    // State register.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; memory outputs depend only on state.
    always_comb begin
        state_d    = state_q;
        oready     = 1'b0;
        omem_req   = 1'b0;
        omem_addr  = '0;
        omem_wdata = '0;
        omem_wstrb = 4'b0000;
        odone      = 1'b0;
        oerr       = 1'b0;
        case (state_q)
            S_IDLE: begin
                oready = 1'b1;
                if (ivalid) begin
                    state_d = legal ? S_REQ0 : S_DONE;
                end
            end
            S_REQ0: begin
                omem_req   = 1'b1;
                omem_addr  = base_q;
                omem_wdata = wdata_q;
                omem_wstrb = strb0_q;
                if (imem_ack) begin
                    state_d = (strb1_q != 4'b0000) ? S_REQ1 : S_DONE;
                end
            end
            S_REQ1: begin
                omem_req   = 1'b1;
                omem_addr  = base_q + MP_ADDR_WIDTH'(4);
                omem_wdata = wdata_q;
                omem_wstrb = strb1_q;
                if (imem_ack) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                odone   = 1'b1;
                oerr    = err_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_riscv_dp_storeenc.sv
// Self-checking bench for riscv_dp_storeenc: directed cases plus random
// stores checked against a lane-level reference model.
module tb_riscv_dp_storeenc;

    logic        iclk = 1'b0;
    logic        irst;
    logic        ivalid;
    logic        oready;
    logic [31:0] iaddr;
    logic [31:0] idata;
    logic [2:0]  ifunct3;
    logic        omem_req;
    logic        imem_ack;
    logic [31:0] omem_addr;
    logic [31:0] omem_wdata;
    logic [3:0]  omem_wstrb;
    logic        odone;
    logic        oerr;

    int errors = 0;
    int checks = 0;

    riscv_dp_storeenc #(.MP_DATA_WIDTH(32), .MP_ADDR_WIDTH(32)) dut (
        .iclk       (iclk),
        .irst       (irst),
        .ivalid     (ivalid),
        .oready     (oready),
        .iaddr      (iaddr),
        .idata      (idata),
        .ifunct3    (ifunct3),
        .omem_req   (omem_req),
        .imem_ack   (imem_ack),
        .omem_addr  (omem_addr),
        .omem_wdata (omem_wdata),
        .omem_wstrb (omem_wstrb),
        .odone      (odone),
        .oerr       (oerr)
    );

    // Free-running clock, rising edge active.
    always #5 iclk = ~iclk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge iclk);
        @(negedge iclk);
    endtask

    // Everything quiet, ready for a new store.
    task automatic checkIdle(input string tag);
        checkOutput({tag, ".ready"}, 32'(oready), 32'd1);
        checkOutput({tag, ".req"},   32'(omem_req), 32'd0);
        checkOutput({tag, ".addr"},  omem_addr, 32'd0);
        checkOutput({tag, ".wdata"}, omem_wdata, 32'd0);
        checkOutput({tag, ".wstrb"}, 32'(omem_wstrb), 32'd0);
        checkOutput({tag, ".done"},  32'(odone), 32'd0);
        checkOutput({tag, ".err"},   32'(oerr), 32'd0);
    endtask

    // Issue one store at a negedge in IDLE and check every following cycle
    // against the model; dly is the number of wait cycles before each ack.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d,
                                 input logic [2:0] f3, input int dly);
        int          nbytes;
        int          off;
        logic [7:0]  lanes;
        logic [63:0] w;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_strb [2];
        logic [31:0] exp_addr [2];
        int          nbeats;
        bit          illegal;

        illegal = (f3 > 3'd2);
        nbytes  = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        off     = int'(a % 4);
        lanes   = 8'h00;
        for (int i = 0; i < nbytes; i++) lanes[off + i] = 1'b1;
        exp_strb[0] = lanes[3:0];
        exp_strb[1] = lanes[7:4];
        nbeats      = (lanes[7:4] != 4'h0) ? 2 : 1;
        exp_addr[0] = a - (a % 4);
        exp_addr[1] = exp_addr[0] + 32'd4;
        w           = {32'd0, d};
        exp_wdata   = 32'(w << (8 * off)) | 32'(w >> (32 - 8 * off));

        checkOutput("acc.ready", 32'(oready), 32'd1);
        ivalid  = 1'b1;
        iaddr   = a;
        idata   = d;
        ifunct3 = f3;
        step();
        ivalid  = 1'b0;
        iaddr   = $urandom;
        idata   = $urandom;
        ifunct3 = 3'($urandom);

        if (illegal) begin
            checkOutput("ill.req",   32'(omem_req), 32'd0);
            checkOutput("ill.done",  32'(odone), 32'd1);
            checkOutput("ill.err",   32'(oerr), 32'd1);
            checkOutput("ill.ready", 32'(oready), 32'd0);
            step();
            checkIdle("ill.after");
        end else begin
            for (int b = 0; b < nbeats; b++) begin
                for (int c = 0; c <= dly; c++) begin
                    checkOutput($sformatf("b%0d.req", b),   32'(omem_req), 32'd1);
                    checkOutput($sformatf("b%0d.addr", b),  omem_addr, exp_addr[b]);
                    checkOutput($sformatf("b%0d.wdata", b), omem_wdata, exp_wdata);
                    checkOutput($sformatf("b%0d.wstrb", b), 32'(omem_wstrb), 32'(exp_strb[b]));
                    checkOutput($sformatf("b%0d.done", b),  32'(odone), 32'd0);
                    checkOutput($sformatf("b%0d.ready", b), 32'(oready), 32'd0);
                    imem_ack = (c == dly);
                    step();
                    imem_ack = 1'b0;
                end
            end
            checkOutput("fin.done",  32'(odone), 32'd1);
            checkOutput("fin.err",   32'(oerr), 32'd0);
            checkOutput("fin.req",   32'(omem_req), 32'd0);
            checkOutput("fin.ready", 32'(oready), 32'd0);
            step();
            checkIdle("fin.after");
        end
    endtask

    initial begin
        irst     = 1'b1;
        ivalid   = 1'b0;
        iaddr    = '0;
        idata    = '0;
        ifunct3  = 3'd0;
        imem_ack = 1'b0;
        #2;
        checkOutput("rst.req",   32'(omem_req), 32'd0);
        checkOutput("rst.ready", 32'(oready), 32'd1);
        repeat (2) @(negedge iclk);
        irst = 1'b0;
        step();
        checkIdle("rst");

        // An ack while idle must be ignored.
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        checkIdle("stray_ack");

        applyStimulus(32'h0000_1002, 32'h0000_00A5, 3'b000, 0);
        applyStimulus(32'h0000_2000, 32'hDEAD_BEEF, 3'b010, 3);
        applyStimulus(32'h0000_3001, 32'h1122_3344, 3'b010, 0);
        applyStimulus(32'hFFFF_FFFF, 32'h0000_BEEF, 3'b001, 1);
        applyStimulus(32'h0000_4000, 32'h1234_5678, 3'b011, 0);
        applyStimulus(32'h0000_5002, 32'hCAFE_F00D, 3'b001, 0);

        // Reset while the second beat waits for its ack.
        checkOutput("ab.ready0", 32'(oready), 32'd1);
        ivalid  = 1'b1;
        iaddr   = 32'h0000_3001;
        idata   = 32'h1122_3344;
        ifunct3 = 3'b010;
        step();
        ivalid   = 1'b0;
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        checkOutput("ab.req1",  32'(omem_req), 32'd1);
        checkOutput("ab.addr1", omem_addr, 32'h0000_3004);
        checkOutput("ab.strb1", 32'(omem_wstrb), 32'h1);
        #2 irst = 1'b1;
        #1;
        checkOutput("ab.req_drop", 32'(omem_req), 32'd0);
        checkOutput("ab.done",     32'(odone), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            checkOutput("ab.hold_done", 32'(odone), 32'd0);
        end
        irst = 1'b0;
        step();
        checkIdle("ab.after");
        applyStimulus(32'h0000_6003, 32'h0000_0077, 3'b000, 0);

        // Random stores, mostly legal widths with occasional illegal funct3.
        for (int n = 0; n < 60; n++) begin
            logic [2:0] f3;
            f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            applyStimulus($urandom, $urandom, f3, int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_dp_storeenc.md
Name: riscv_dp_storeenc

Overview:
Store-path encoder for the datapath; it is the write-side counterpart of the load decoder. It accepts one store (sb/sh/sw) per transaction and rotates the store data into byte lanes. It generates per-lane write strobes and drives a req/ack data-memory write port. Misaligned stores that cross a word boundary are split into two word-aligned memory beats by an internal FSM.

Parameters:
MP_DATA_WIDTH, 32, store data / memory word width; fixed at 32 (4 byte lanes)
MP_ADDR_WIDTH, 32, byte address width

Ports:
iclk  input  1  clock; all state updates on rising edge
irst  input  1  asynchronous, active-high reset
ivalid  input  1  store request valid
oready  output  1  block can accept a request (high only in IDLE)
iaddr  input  MP_ADDR_WIDTH  store byte address
idata  input  MP_DATA_WIDTH  rs2 store data, right-justified
ifunct3  input  3  store width: 000 sb, 001 sh, 010 sw; all others illegal
omem_req  output  1  memory write request
imem_ack  input  1  memory accepted current beat
omem_addr  output  MP_ADDR_WIDTH  word-aligned beat address (bits[1:0]=00)
omem_wdata  output  MP_DATA_WIDTH  lane-rotated write data
omem_wstrb  output  4  byte-lane write enables
odone  output  1  one-cycle pulse: transaction complete
oerr  output  1  one-cycle pulse with odone: illegal funct3, no memory access made

Behaviour:
- Reset (async, irst=1): state IDLE; omem_req=0, omem_addr=0, omem_wdata=0, omem_wstrb=0, odone=0, oerr=0; oready=1 once in IDLE. Reset mid-transaction aborts the transaction, drops omem_req immediately and issues no odone.
- Accept: handshake on the rising edge with ivalid & oready. iaddr, idata and ifunct3 are registered at accept; later input changes have no effect.
- off = iaddr[1:0]. wdata = idata rotated left by 8*off. omem_wdata carries the same rotated word in both beats.
- Base mask: sb 0001, sh 0011, sw 1111. Shift the base mask left by off into 7 bits. Bits[3:0] form the beat-0 strobe; bits[6:4] padded with 0 form the beat-1 strobe.
- The transaction splits when the beat-1 strobe is nonzero: sh at off=3, or sw at off≠0.
- Beat-0 address = {iaddr[MSB:2], 2'b00}. Beat-1 address = beat-0 + 4, wrapping modulo 2^MP_ADDR_WIDTH.
- FSM states:
  - IDLE: oready=1. Legal accept -> REQ0. Illegal funct3 accept -> DONE with error flag set.
  - REQ0: omem_req=1; addr/wdata/wstrb hold beat 0, stable until ack. On imem_ack: -> REQ1 if split, else -> DONE.
  - REQ1: omem_req=1 with beat-1 address/strobe. On imem_ack -> DONE.
  - DONE: odone=1 for exactly one cycle; oerr=1 only if error flag set. Next state IDLE; error flag cleared.
- Outside REQ0/REQ1: omem_req=0, omem_addr/omem_wdata/omem_wstrb=0.
- imem_ack sampled only while omem_req=1; an ack in IDLE/DONE is ignored. Ack may arrive in the first cycle req is high.
- Latency, with accept at edge N and zero-wait ack:
  - Unsplit: req high in cycle N+1, odone in cycle N+2, oready high again in cycle N+3.
  - Split: one extra cycle.
- Back-to-back requests: the next accept occurs no earlier than the cycle after odone.
- Outputs are registered from state; there is no combinational path from ivalid to omem_*.

Test Plan:
- sb, iaddr=0x1002, idata=0x000000A5, ack immediate -> single beat: omem_addr=0x1000, wstrb=0100, wdata=0x00A50000; odone 2 cycles after accept.
- sw aligned, iaddr=0x2000, idata=0xDEADBEEF, ack delayed 3 cycles -> req and all omem_* held stable for 4 cycles; wstrb=1111, wdata=0xDEADBEEF; single odone.
- sw misaligned, iaddr=0x3001, idata=0x11223344 -> beat0 addr 0x3000 strb 1110 wdata 0x22334411; beat1 addr 0x3004 strb 0001; odone after the second ack.
- sh at off=3, iaddr=0xFFFFFFFF, idata=0x0000BEEF -> beat0 addr 0xFFFFFFFC strb 1000; beat1 addr 0x00000000 (wrap) strb 0001; wdata 0xEFxxxxBE in lanes 3/0.
- Illegal funct3=011 -> no omem_req asserted; odone=oerr=1 for one cycle, cycle N+1; oready returns cycle N+2.
- irst asserted while in REQ1 with ack withheld -> omem_req drops asynchronously, no odone; after release oready=1 and a new sb completes normally.
